seq_det_ctrl: RTL and testbench

- Controller and configurable datapath for serial bit-pattern detection, generalising the fixed 1011 detector.
- Holds pattern, length, overlap mode and match target as configuration registers.
- Arms and disarms detection, counts matches, and signals done when the target count is reached.
- Sits between a serial bit source and the control logic that consumes match events.

---
 rtl/seq_det_ctrl.sv | 115 +++++++++++
 tb/tb_seq_det_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: configurable serial pattern detector with arm/disarm control,
// a saturating match counter and a done state once a nonzero target is hit.
module seq_det_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  input  logic [CNT_W-1:0]             cfg_target,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         ip,
  input  logic                         ip_valid,
  output logic                         op,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_err
);
  localparam int LW = $clog2(MAX_LEN+1);

  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

  state_t             state, state_nxt;
  logic [MAX_LEN-1:0] pat, hist, hist_nxt, mask;
  logic [LW-1:0]      len, fill;
  logic [LW:0]        fill_p1;
  logic               ovl;
  logic [CNT_W-1:0]   tgt, cnt_nxt;
  logic               cfg_open, cfg_bad, arm, shift, match;

  // Datapath decode and next-state logic; busy/done are pure state decodes
  always_comb begin
    cfg_open  = (state != ARMED);
    cfg_bad   = (cfg_len == '0) || (cfg_len > LW'(MAX_LEN));
    arm       = start && cfg_open;
    // abort beats a same-cycle valid bit, so the bit is never evaluated
    shift     = (state == ARMED) && ip_valid && !abort;
    hist_nxt  = {hist[MAX_LEN-2:0], ip};
    fill_p1   = {1'b0, fill} + (LW+1)'(1);
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (LW'(i) < len);
    match     = shift && (fill_p1 >= {1'b0, len}) &&
                ((hist_nxt & mask) == (pat & mask));
    cnt_nxt   = (match_cnt == '1) ? match_cnt : match_cnt + CNT_W'(1);
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = ARMED;
      ARMED: begin
        busy = 1'b1;
        if (abort) state_nxt = IDLE;
        else if (match && (tgt != '0) && (cnt_nxt == tgt)) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = ARMED;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Configuration registers; writes are locked out while armed
  always_ff @(posedge clk) begin
    if (rst) begin
      pat     <= MAX_LEN'(11);
      len     <= LW'(4);
      ovl     <= 1'b1;
      tgt     <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && cfg_open && cfg_bad;
      if (cfg_we && cfg_open && !cfg_bad) begin
        pat <= cfg_pattern;
        len <= cfg_len;
        ovl <= cfg_overlap;
        tgt <= cfg_target;
      end
    end
  end

  // History shift, fill tracking, match counting and the registered match pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
      op        <= 1'b0;
    end else begin
      op <= match;
      if (arm) begin
        hist      <= '0;
        fill      <= '0;
        match_cnt <= '0;
      end else if (shift) begin
        hist <= hist_nxt;
        // without overlap a match consumes its bits: restart the fill count
        if (match && !ovl)            fill <= '0;
        else if (fill_p1 >= {1'b0, len}) fill <= len;
        else                          fill <= fill_p1[LW-1:0];
        if (match) match_cnt <= cnt_nxt;
      end
    end
  end
endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed scenarios plus a randomized run, all
// checked against a bit-queue reference model of the detector.
module tb_seq_det_ctrl;
  localparam int ML = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst, cfg_we, cfg_overlap, start, abort, ip, ip_valid;
  logic [ML-1:0] cfg_pattern;
  logic [3:0]    cfg_len;
  logic [CW-1:0] cfg_target;
  logic          op, busy, done, cfg_err;
  logic [CW-1:0] match_cnt;

  int errors = 0;
  int checks = 0;

  // reference model: received bits since arming, newest at the back
  bit       q[$];
  int       m_state;  // 0 idle, 1 armed, 2 done
  logic [7:0] m_pat, m_tgt;
  int       m_len;
  bit       m_ovl, m_op, m_err;
  int       m_cnt;

  seq_det_ctrl #(.MAX_LEN(ML), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
    .start(start), .abort(abort), .ip(ip), .ip_valid(ip_valid),
    .op(op), .match_cnt(match_cnt), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic model(input bit r, we, input logic [7:0] p, input int l,
                       input bit o, input logic [7:0] t, input bit s, a, b, v);
    bit hit;
    m_op = 0; m_err = 0;
    if (r) begin
      m_state = 0; m_pat = 8'h0B; m_len = 4; m_ovl = 1; m_tgt = 0;
      q.delete(); m_cnt = 0;
    end else if (m_state != 1) begin
      if (we) begin
        if (l == 0 || l > ML) m_err = 1;
        else begin m_pat = p; m_len = l; m_ovl = o; m_tgt = t; end
      end
      if (s) begin m_state = 1; q.delete(); m_cnt = 0; end
    end else if (a) begin
      m_state = 0;
    end else if (v) begin
      q.push_back(b);
      if (q.size() > m_len) void'(q.pop_front());
      if (q.size() == m_len) begin
        hit = 1;
        for (int i = 0; i < m_len; i++) if (q[i] != m_pat[m_len-1-i]) hit = 0;
        if (hit) begin
          m_op = 1;
          if (m_cnt < 255) m_cnt++;
          if (!m_ovl) q.delete();
          if (m_tgt != 0 && m_cnt == m_tgt) m_state = 2;
        end
      end
    end
  endtask

  // drive one cycle of inputs, advance the model, sample 1ns after the edge
  task automatic step(input bit r, we, input logic [7:0] p, input logic [3:0] l,
                      input bit o, input logic [7:0] t, input bit s, a, b, v);
    rst = r; cfg_we = we; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    cfg_target = t; start = s; abort = a; ip = b; ip_valid = v;
    model(r, we, p, int'(l), o, t, s, a, b, v);
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst;  step(1, 0, 8'hA5, 4'd7, 0, 8'd3, 0, 0, 0, 0); endtask
  task automatic do_start; step(0, 0, 8'h00, 4'd0, 0, 8'd0, 1, 0, 0, 0); endtask
  task automatic bit_in(input bit b); step(0, 0, 8'h00, 4'd0, 0, 8'd0, 0, 0, b, 1); endtask
  task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input bit o,
                        input logic [7:0] t);
    step(0, 1, p, l, o, t, 0, 0, 0, 0);
  endtask

  task automatic test_reset;
    do_rst();
    checks++;
    if ({op, busy, done, cfg_err} !== 4'b0 || match_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset: op=%b busy=%b done=%b err=%b cnt=%0d expected all 0",
               op, busy, done, cfg_err, match_cnt);
    end
  endtask

  task automatic test_default_overlap;
    logic [6:0] s;
    logic exp;
    s = 7'b1011011;
    do_rst(); do_start();
    for (int k = 0; k < 7; k++) begin
      bit_in(s[6-k]);
      exp = (k == 3 || k == 6);
      checks++;
      if (op !== exp) begin errors++; $display("FAIL overlap_op bit%0d: op=%b expected %b", k, op, exp); end
    end
    checks++;
    if (match_cnt !== 8'd2 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL overlap_end: cnt=%0d busy=%b done=%b expected 2 1 0", match_cnt, busy, done);
    end
  endtask

  task automatic test_no_overlap;
    logic [6:0] s;
    logic exp;
    s = 7'b1011011;
    do_rst(); do_cfg(8'h0B, 4'd4, 0, 8'd0); do_start();
    for (int k = 0; k < 7; k++) begin
      bit_in(s[6-k]);
      exp = (k == 3);
      checks++;
      if (op !== exp) begin errors++; $display("FAIL nooverlap_op bit%0d: op=%b expected %b", k, op, exp); end
    end
    checks++;
    if (match_cnt !== 8'd1) begin errors++; $display("FAIL nooverlap_cnt: cnt=%0d expected 1", match_cnt); end
  endtask

  task automatic test_target;
    logic [10:0] s;
    logic exp;
    s = 11'b1011011_1011;
    do_rst(); do_cfg(8'h0B, 4'd4, 1, 8'd2); do_start();
    for (int k = 0; k < 11; k++) begin
      bit_in(s[10-k]);
      exp = (k == 3 || k == 6);
      checks++;
      if (op !== exp) begin errors++; $display("FAIL target_op bit%0d: op=%b expected %b", k, op, exp); end
      if (k == 6) begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          errors++; $display("FAIL target_done: done=%b busy=%b expected 1 0", done, busy);
        end
      end
    end
    checks++;
    if (match_cnt !== 8'd2 || done !== 1'b1) begin
      errors++; $display("FAIL target_hold: cnt=%0d done=%b expected 2 1", match_cnt, done);
    end
  endtask

  task automatic test_cfg_err;
    logic [3:0] s;
    logic exp;
    s = 4'b1011;
    do_rst();
    do_cfg(8'h07, 4'd0, 0, 8'd1);
    checks++;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_len0: err=%b expected 1", cfg_err); end
    do_cfg(8'h07, 4'd9, 0, 8'd1);
    checks++;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_len9: err=%b expected 1", cfg_err); end
    do_start();
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_pulse: err=%b expected 0", cfg_err); end
    for (int k = 0; k < 4; k++) begin
      bit_in(s[3-k]);
      exp = (k == 3);
      checks++;
      if (op !== exp) begin errors++; $display("FAIL cfg_err_keep bit%0d: op=%b expected %b", k, op, exp); end
    end
  endtask

  task automatic test_cfg_lockout;
    logic [4:0] s;
    logic exp;
    s = 5'b11011;
    do_rst(); do_start();
    do_cfg(8'b110, 4'd3, 1, 8'd0);
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL lockout_err: err=%b expected 0", cfg_err); end
    for (int k = 0; k < 5; k++) begin
      bit_in(s[4-k]);
      exp = (k == 4);
      checks++;
      if (op !== exp) begin errors++; $display("FAIL lockout_op bit%0d: op=%b expected %b", k, op, exp); end
    end
  endtask

  task automatic test_gaps;
    logic [3:0] s;
    int ops;
    s = 4'b1011;
    ops = 0;
    do_rst(); do_start();
    for (int k = 0; k < 4; k++) begin
      bit_in(s[3-k]);
      ops += int'(op);
      if (k == 1)
        for (int g = 0; g < 3; g++) begin
          step(0, 0, 8'h00, 4'd0, 0, 8'd0, 0, 0, 1, 0);
          ops += int'(op);
        end
    end
    checks++;
    if (ops != 1 || match_cnt !== 8'd1) begin
      errors++; $display("FAIL gaps: ops=%0d cnt=%0d expected 1 1", ops, match_cnt);
    end
  endtask

  task automatic test_abort;
    logic [5:0] s;
    s = 6'b101101;
    do_rst(); do_start();
    for (int k = 0; k < 6; k++) bit_in(s[5-k]);
    step(0, 0, 8'h00, 4'd0, 0, 8'd0, 0, 1, 1, 1);
    checks++;
    if (op !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || match_cnt !== 8'd1) begin
      errors++;
      $display("FAIL abort: op=%b busy=%b done=%b cnt=%0d expected 0 0 0 1", op, busy, done, match_cnt);
    end
  endtask

  task automatic test_rst_armed;
    logic [3:0] s;
    logic exp;
    s = 4'b1011;
    do_rst(); do_cfg(8'b111, 4'd3, 0, 8'd5); do_start();
    bit_in(1); bit_in(0); bit_in(1);
    do_rst();
    checks++;
    if ({op, busy, done, cfg_err} !== 4'b0 || match_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_armed: op=%b busy=%b done=%b err=%b cnt=%0d expected all 0",
               op, busy, done, cfg_err, match_cnt);
    end
    do_start();
    for (int k = 0; k < 4; k++) begin
      bit_in(s[3-k]);
      exp = (k == 3);
      checks++;
      if (op !== exp) begin errors++; $display("FAIL rst_restart bit%0d: op=%b expected %b", k, op, exp); end
    end
  endtask

  task automatic test_random;
    bit r, we, o, s, a, b, v;
    logic [7:0] p, t;
    logic [3:0] l;
    do_rst();
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 299) == 0);
      we = ($urandom_range(0, 15) == 0);
      p  = 8'($urandom);
      l  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 10)) : 4'($urandom_range(1, 4));
      o  = 1'($urandom);
      t  = 8'($urandom_range(0, 5));
      s  = ($urandom_range(0, 19) == 0);
      a  = ($urandom_range(0, 39) == 0);
      b  = 1'($urandom);
      v  = ($urandom_range(0, 3) != 0);
      step(r, we, p, l, o, t, s, a, b, v);
      checks++;
      if (op !== m_op || match_cnt !== 8'(m_cnt) || busy !== (m_state == 1) ||
          done !== (m_state == 2) || cfg_err !== m_err) begin
        errors++;
        $display("FAIL random cyc%0d: op=%b cnt=%0d busy=%b done=%b err=%b expected %b %0d %b %b %b",
                 n, op, match_cnt, busy, done, cfg_err, m_op, m_cnt, m_state == 1, m_state == 2, m_err);
      end
    end
  endtask

  initial begin
    rst = 1; cfg_we = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
    cfg_target = '0; start = 0; abort = 0; ip = 0; ip_valid = 0;
    test_reset();
    test_default_overlap();
    test_no_overlap();
    test_target();
    test_cfg_err();
    test_cfg_lockout();
    test_gaps();
    test_abort();
    test_rst_armed();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
